// File: rtl/axi_fifo_pkt_arb_pkg.sv
// Shared types and constants for the packet round-robin arbiter and its picker.
package axi_fifo_pkt_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } arb_state_e;

  localparam int SPACE_W = 16;
  localparam int NUM_INPUTS_DEF = 4;

  // At least one bit so a two-input arbiter still has a usable index.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int IDX_W_DEF = idx_width(NUM_INPUTS_DEF);

endpackage

// File: rtl/axi_arb_rr_pick.sv
// Combinational round-robin picker: first requester above last_winner, wrapping.
module axi_arb_rr_pick
  import axi_fifo_pkt_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_winner,
  output logic             found,
  output logic [IDX_W-1:0] winner,
  output logic [N-1:0]     winner_oh
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    found     = 1'b0;
    winner    = '0;
    winner_oh = '0;
    cand      = '0;
    // Offset N lands back on last_winner, so it has the lowest priority.
    for (int i = 1; i <= N; i++) begin
      cand = IDX_W'((int'(last_winner) + i) % N);
      if (!found && req[cand]) begin
        found           = 1'b1;
        winner          = cand;
        winner_oh[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_fifo_pkt_arb.sv
// Packet-granular round-robin arbiter feeding one shared FIFO, gated on its free space.
module axi_fifo_pkt_arb
  import axi_fifo_pkt_arb_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int NUM_INPUTS = 4,
  parameter int MIN_SPACE  = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        clear,
  input  logic [NUM_INPUTS*WIDTH-1:0] i_tdata,
  input  logic [NUM_INPUTS-1:0]       i_tlast,
  input  logic [NUM_INPUTS-1:0]       i_tvalid,
  output logic [NUM_INPUTS-1:0]       i_tready,
  output logic [WIDTH-1:0]            o_tdata,
  output logic                        o_tlast,
  output logic                        o_tvalid,
  input  logic                        o_tready,
  input  logic [SPACE_W-1:0]          fifo_space,
  output logic [NUM_INPUTS-1:0]       grant,
  output logic                        active
);

  localparam int IDX_W = idx_width(NUM_INPUTS);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_INPUTS - 1);

  arb_state_e             state;
  logic [IDX_W-1:0]       gidx;
  logic [IDX_W-1:0]       last_winner;
  logic                   found;
  logic [IDX_W-1:0]       winner;
  logic [NUM_INPUTS-1:0]  winner_oh;
  logic                   space_ok;
  logic [WIDTH-1:0]       lane [NUM_INPUTS];

  axi_arb_rr_pick #(
    .N     (NUM_INPUTS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req         (i_tvalid),
    .last_winner (last_winner),
    .found       (found),
    .winner      (winner),
    .winner_oh   (winner_oh)
  );

  for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_lane
    assign lane[k] = i_tdata[k*WIDTH +: WIDTH];
  end

  assign space_ok = (MIN_SPACE == 0) || (fifo_space >= SPACE_W'(MIN_SPACE));
  assign active   = (state == ST_ACTIVE);

  always_comb begin
    i_tready = '0;
    o_tdata  = '0;
    o_tlast  = 1'b0;
    o_tvalid = 1'b0;
    if (state == ST_ACTIVE) begin
      o_tdata        = lane[gidx];
      o_tlast        = i_tlast[gidx];
      o_tvalid       = i_tvalid[gidx];
      i_tready[gidx] = o_tready;
    end
  end

  // clear drops the packet but keeps last_winner so fairness survives an abort.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      grant       <= '0;
      gidx        <= '0;
      last_winner <= LAST_RST;
    end else if (clear) begin
      state <= ST_IDLE;
      grant <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found && space_ok) begin
            state       <= ST_ACTIVE;
            grant       <= winner_oh;
            gidx        <= winner;
            last_winner <= winner;
          end
        end
        ST_ACTIVE: begin
          if (o_tvalid && o_tready && o_tlast) begin
            state <= ST_IDLE;
            grant <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_fifo_pkt_arb.sv
// Directed bench for axi_fifo_pkt_arb: per-cycle vector table plus multi-cycle sequences.
module tb_axi_fifo_pkt_arb;

  localparam int W = 32;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           clear = 1'b0;
  logic [N*W-1:0] i_tdata = '0;
  logic [N-1:0]   i_tlast = '0;
  logic [N-1:0]   i_tvalid = '0;
  logic [N-1:0]   i_tready;
  logic [W-1:0]   o_tdata;
  logic           o_tlast;
  logic           o_tvalid;
  logic           o_tready = 1'b1;
  logic [15:0]    fifo_space = 16'd100;
  logic [N-1:0]   grant;
  logic           active;

  int n_cmp = 0;
  int n_bad = 0;

  axi_fifo_pkt_arb #(.WIDTH(W), .NUM_INPUTS(N), .MIN_SPACE(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .i_tdata    (i_tdata),
    .i_tlast    (i_tlast),
    .i_tvalid   (i_tvalid),
    .i_tready   (i_tready),
    .o_tdata    (o_tdata),
    .o_tlast    (o_tlast),
    .o_tvalid   (o_tvalid),
    .o_tready   (o_tready),
    .fifo_space (fifo_space),
    .grant      (grant),
    .active     (active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [15:0] space;
    logic        ordy;
    logic [31:0] dbase;
    logic [3:0]  e_grant;
    logic        e_active;
    logic        e_ovalid;
    logic        e_olast;
    logic [3:0]  e_irdy;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_data(input logic [31:0] base);
    for (int k = 0; k < N; k++) i_tdata[k*W +: W] = base + 32'(k);
  endtask

  function automatic int oh_idx(input logic [3:0] oh);
    int r;
    r = 0;
    for (int k = 0; k < N; k++) if (oh[k]) r = k;
    return r;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // valid, last, space, ordy, dbase, e_grant, e_active, e_ovalid, e_olast, e_irdy
    vecs.push_back('{4'b0100, 4'b0000, 16'd100, 1'b1, 32'h100, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000});
    vecs.push_back('{4'b0100, 4'b0000, 16'd100, 1'b1, 32'h110, 4'b0100, 1'b1, 1'b1, 1'b0, 4'b0100});
    vecs.push_back('{4'b0100, 4'b0000, 16'd100, 1'b1, 32'h120, 4'b0100, 1'b1, 1'b1, 1'b0, 4'b0100});
    vecs.push_back('{4'b0100, 4'b0100, 16'd100, 1'b1, 32'h130, 4'b0100, 1'b1, 1'b1, 1'b1, 4'b0100});
    vecs.push_back('{4'b0000, 4'b0000, 16'd100, 1'b1, 32'h140, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000});
    vecs.push_back('{4'b0010, 4'b0000, 16'd15,  1'b1, 32'h150, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000});
    vecs.push_back('{4'b0010, 4'b0000, 16'd15,  1'b1, 32'h150, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000});
    vecs.push_back('{4'b0010, 4'b0010, 16'd16,  1'b1, 32'h160, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000});
    vecs.push_back('{4'b0010, 4'b0010, 16'd16,  1'b1, 32'h170, 4'b0010, 1'b1, 1'b1, 1'b1, 4'b0010});
    vecs.push_back('{4'b0000, 4'b0000, 16'd100, 1'b1, 32'h180, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000});
    vecs.push_back('{4'b1000, 4'b0000, 16'd100, 1'b0, 32'h190, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000});
    vecs.push_back('{4'b1000, 4'b0000, 16'd100, 1'b1, 32'h1a0, 4'b1000, 1'b1, 1'b1, 1'b0, 4'b1000});
    vecs.push_back('{4'b1000, 4'b0000, 16'd100, 1'b0, 32'h1b0, 4'b1000, 1'b1, 1'b1, 1'b0, 4'b0000});
    vecs.push_back('{4'b1000, 4'b0000, 16'd100, 1'b1, 32'h1b0, 4'b1000, 1'b1, 1'b1, 1'b0, 4'b1000});
    vecs.push_back('{4'b1000, 4'b1000, 16'd100, 1'b0, 32'h1c0, 4'b1000, 1'b1, 1'b1, 1'b1, 4'b0000});
    vecs.push_back('{4'b1000, 4'b1000, 16'd100, 1'b1, 32'h1c0, 4'b1000, 1'b1, 1'b1, 1'b1, 4'b1000});
    vecs.push_back('{4'b0000, 4'b0000, 16'd100, 1'b1, 32'h1d0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000});

    set_data(32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_grant", 32'(grant), 32'h0);
    chk("reset_active", 32'(active), 32'h0);
    chk("reset_ovalid", 32'(o_tvalid), 32'h0);
    chk("reset_irdy", 32'(i_tready), 32'h0);
    reset_n = 1'b1;
    next_cycle();

    foreach (vecs[r]) begin
      i_tvalid   = vecs[r].valid;
      i_tlast    = vecs[r].last;
      fifo_space = vecs[r].space;
      o_tready   = vecs[r].ordy;
      set_data(vecs[r].dbase);
      @(negedge clk);
      chk($sformatf("v%0d_grant", r), 32'(grant), 32'(vecs[r].e_grant));
      chk($sformatf("v%0d_active", r), 32'(active), 32'(vecs[r].e_active));
      chk($sformatf("v%0d_ovalid", r), 32'(o_tvalid), 32'(vecs[r].e_ovalid));
      chk($sformatf("v%0d_olast", r), 32'(o_tlast), 32'(vecs[r].e_olast));
      chk($sformatf("v%0d_irdy", r), 32'(i_tready), 32'(vecs[r].e_irdy));
      if (vecs[r].e_ovalid)
        chk($sformatf("v%0d_odata", r), o_tdata, vecs[r].dbase + 32'(oh_idx(vecs[r].e_grant)));
      next_cycle();
    end

    // Round robin: all requesting, 2-beat packets, last_winner starts at 3.
    begin
      int order [5] = '{0, 1, 2, 3, 0};
      i_tvalid   = 4'b1111;
      fifo_space = 16'd100;
      o_tready   = 1'b1;
      set_data(32'h200);
      for (int p = 0; p < 5; p++) begin
        i_tlast = 4'b0000;
        @(negedge clk);
        chk($sformatf("rr%0d_gap_grant", p), 32'(grant), 32'h0);
        chk($sformatf("rr%0d_gap_ovalid", p), 32'(o_tvalid), 32'h0);
        next_cycle();
        for (int b = 0; b < 2; b++) begin
          i_tlast = (b == 1) ? 4'b1111 : 4'b0000;
          @(negedge clk);
          chk($sformatf("rr%0d_b%0d_grant", p, b), 32'(grant), 32'(1) << order[p]);
          chk($sformatf("rr%0d_b%0d_olast", p, b), 32'(o_tlast), 32'(b));
          chk($sformatf("rr%0d_b%0d_odata", p, b), o_tdata, 32'h200 + 32'(order[p]));
          next_cycle();
        end
      end
    end

    // clear on beat 2 of an input-0 packet; last_winner stays 0, so input 1 wins next.
    i_tvalid = 4'b0001;
    i_tlast  = 4'b0000;
    next_cycle();
    @(negedge clk);
    chk("clr_beat1_grant", 32'(grant), 32'h1);
    next_cycle();
    clear = 1'b1;
    @(negedge clk);
    chk("clr_beat2_grant", 32'(grant), 32'h1);
    next_cycle();
    clear    = 1'b0;
    i_tvalid = 4'b0011;
    @(negedge clk);
    chk("clr_after_grant", 32'(grant), 32'h0);
    chk("clr_after_active", 32'(active), 32'h0);
    chk("clr_after_ovalid", 32'(o_tvalid), 32'h0);
    next_cycle();
    @(negedge clk);
    chk("clr_next_grant", 32'(grant), 32'h2);

    // Asynchronous reset mid-packet, away from any clock edge.
    next_cycle();
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_grant", 32'(grant), 32'h0);
    chk("arst_active", 32'(active), 32'h0);
    chk("arst_ovalid", 32'(o_tvalid), 32'h0);
    chk("arst_irdy", 32'(i_tready), 32'h0);
    @(negedge clk);
    i_tvalid = 4'b1111;
    reset_n  = 1'b1;
    next_cycle();
    chk("arst_first_grant", 32'(grant), 32'h1);
    chk("arst_first_active", 32'(active), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
